// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared constants and state encoding for the right shifter
package shifter_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/right_shift_step.sv
// rtl/right_shift_step.sv - one combinational right shift/rotate step of size k
module right_shift_step
  import shifter_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic [4:0]        k,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] shifted,
  output logic              out_bit
);

  logic [5:0] left_amt;

  // Rotate is built from two logical shifts; a left shift by 32 (k = 0) yields 0,
  // so the rotate degenerates to the identity as it should.
  assign left_amt = 6'd32 - {1'b0, k};

  // Select fill behaviour by mode; mode 11 falls through to LSR.
  always_comb begin
    shifted = value >> k;
    case (mode)
      MODE_ASR: shifted = $signed(value) >>> k;
      MODE_ROR: shifted = (value >> k) | (value << left_amt);
      default:  shifted = value >> k;
    endcase
    // The last bit leaving the bottom is value[k-1]; nothing leaves when k = 0.
    out_bit = (k != 5'd0) ? value[k - 5'd1] : 1'b0;
  end

endmodule

// File: rtl/right_shift_unit.sv
// rtl/right_shift_unit.sv - iterative LSR/ASR/ROR unit shifting up to STEP bits per cycle
module right_shift_unit
  import shifter_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [4:0]        amount,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
);

  localparam logic [4:0] STEP_K = 5'(STEP);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [4:0]        remaining;
  logic [1:0]        mode_q;
  logic [4:0]        k;
  logic [4:0]        remaining_next;
  logic [DATA_W-1:0] step_value;
  logic              step_bit;

  // Step size is the smaller of what is left and the per-cycle limit, so
  // remaining can never wrap below zero.
  always_comb begin
    k              = (remaining < STEP_K) ? remaining : STEP_K;
    remaining_next = remaining - k;
  end

  right_shift_step u_step (
    .value   (acc),
    .k       (k),
    .mode    (mode_q),
    .shifted (step_value),
    .out_bit (step_bit)
  );

  // Control FSM plus accumulator, counter and carry registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      mode_q    <= MODE_LSR;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= data;
            remaining <= amount;
            mode_q    <= mode;
            carry_out <= 1'b0;
            state     <= (amount == 5'd0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          acc       <= step_value;
          carry_out <= step_bit;
          remaining <= remaining_next;
          if (remaining_next == 5'd0) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status decodes straight from the state flops, so reset clears them at once.
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign result = acc;

endmodule

// File: tb/tb_right_shift_unit.sv
// tb/tb_right_shift_unit.sv - directed table-driven bench for right_shift_unit
module tb_right_shift_unit;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] data;
    logic [4:0]  amount;
    logic [31:0] exp_res;
    logic        exp_c;
    int          exp_lat;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] data;
  logic [4:0]  amount;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  int checks;
  int failures;

  vec_t vecs[13];

  right_shift_unit #(.STEP(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data      (data),
    .amount    (amount),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Launch one operation; a stray start is made visible to the DUT at edge 'poke'
  // (0 disables it). Returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input vec_t v, input int poke);
    int lat;
    bit got;
    @(posedge clk); #1;
    start  = 1'b1;
    data   = v.data;
    amount = v.amount;
    mode   = v.mode;
    @(negedge clk);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    check({tag, " idle_done"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    lat    = 1;
    start  = (poke == lat + 1);
    data   = $urandom;
    amount = 5'($urandom);
    mode   = 2'($urandom);
    got    = 1'b0;
    while (!got && lat <= 40) begin
      @(negedge clk);
      check({tag, " busy"}, 32'(busy), 32'd1);
      if (done) begin
        got = 1'b1;
      end else begin
        @(posedge clk); #1;
        lat++;
        start  = (poke == lat + 1);
        data   = $urandom;
        amount = 5'($urandom);
        mode   = 2'($urandom);
      end
    end
    check({tag, " latency"}, got ? 32'(lat) : 32'hFFFF_FFFF, 32'(v.exp_lat));
    if (got) begin
      check({tag, " result"}, result, v.exp_res);
      check({tag, " carry"}, 32'(carry_out), 32'(v.exp_c));
    end
  endtask

  // Hold start low and confirm the unit sits idle with a stable result.
  task automatic idle_check(input string tag, input logic [31:0] exp_res, input int n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, " idle_busy"}, 32'(busy), 32'd0);
      check({tag, " idle_done"}, 32'(done), 32'd0);
      check({tag, " idle_result"}, result, exp_res);
    end
  endtask

  initial begin
    vec_t v;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    data     = '0;
    amount   = '0;
    mode     = '0;

    vecs[0]  = '{2'd0, 32'hF000_0001, 5'd4,  32'h0F00_0000, 1'b0, 2};
    vecs[1]  = '{2'd1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 9};
    vecs[2]  = '{2'd2, 32'h0000_00F1, 5'd8,  32'hF100_0000, 1'b1, 3};
    vecs[3]  = '{2'd1, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1};
    vecs[4]  = '{2'd0, 32'h0000_0100, 5'd8,  32'h0000_0001, 1'b0, 3};
    vecs[5]  = '{2'd0, 32'h0000_0080, 5'd7,  32'h0000_0001, 1'b0, 3};
    vecs[6]  = '{2'd3, 32'h0000_0080, 5'd1,  32'h0000_0040, 1'b0, 2};
    vecs[7]  = '{2'd2, 32'h1234_5678, 5'd31, 32'h2468_ACF0, 1'b0, 9};
    vecs[8]  = '{2'd1, 32'hF000_0000, 5'd5,  32'hFF80_0000, 1'b0, 3};
    vecs[9]  = '{2'd0, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b1, 9};
    vecs[10] = '{2'd2, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1, 2};
    vecs[11] = '{2'd1, 32'h7FFF_FFFF, 5'd3,  32'h0FFF_FFFF, 1'b1, 2};
    vecs[12] = '{2'd2, 32'h0000_00A5, 5'd5,  32'h2800_0005, 1'b0, 3};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    check("reset carry", 32'(carry_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Table: each start lands in the cycle after the previous done
    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i], 0);
    end
    idle_check("after_table", 32'h2800_0005, 3);

    // Stray start during SHIFT is ignored and adds no done
    run_op("asr31_poke", vecs[1], 3);
    idle_check("asr31_poke", 32'hFFFF_FFFF, 4);

    // Start held during the DONE cycle is ignored
    run_op("lsr4_pokedone", vecs[0], 3);
    idle_check("lsr4_pokedone", 32'h0F00_0000, 4);

    // Asynchronous reset in the middle of an operation
    @(posedge clk); #1;
    start  = 1'b1;
    data   = 32'hFFFF_FFFF;
    amount = 5'd20;
    mode   = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort pre busy", 32'(busy), 32'd1);
    check("abort pre result", result, 32'h0FFF_FFFF);
    reset = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", result, 32'd0);
    check("abort carry", 32'(carry_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_check("abort", 32'd0, 4);
    v = vecs[4];
    run_op("after_abort", v, 0);
    idle_check("after_abort", 32'h0000_0001, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
